load_store_unit: RTL and testbench

Initiator side of the data-memory port: converts byte-addressed RV32I load/store requests from the execute stage into word-wide `mem_read`/`mem_write` accesses on the data memory. It sign- or zero-extends loads and performs read-modify-write for byte and halfword stores. It sits between the execute stage and `data_memory` and handles one request at a time.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Purpose: RV32I data-memory initiator; byte/half/word loads with sign/zero extension,
//          sub-word stores by read-modify-write of the addressed word.
// Latency: load 3 cycles, SW 2, SB/SH 4, trapped or unsupported request 1 (cycle 0 = accept edge).
// Backpressure: one request in flight; req_ready is high only in IDLE, requester holds until accepted.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   req_valid/req_ready               request handshake from execute stage
//   req_store, req_funct3, req_addr,  request fields, captured at accept
//   req_wdata
//   resp_valid, resp_rdata,           single-cycle completion pulse with load data / misalign flag
//   resp_misaligned
//   mem_read, mem_write, mem_address, word-wide data memory port; read data arrives the cycle
//   mem_write_data, mem_read_data     after mem_read
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to complete misaligned requests without any
// memory access and with resp_misaligned set. Otherwise low address bits are simply ignored.

module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  store_q;
    logic [15:0]           wdata_q;     // only the low half is needed for SB/SH merging
    logic [31:0]           rdata_q;
    logic [31:0]           wr_data_q;
    logic                  misal_q;

    logic                  accept;
    logic                  unsup;
    logic                  trap;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_fmt;
    logic [31:0]           merged;

    // Request decode: unsupported encodings win over misalignment.
    always_comb begin
        unsup = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   trap = req_addr[0] & ~unsup;
            2'b10:   trap = (req_addr[1:0] != 2'b00) & ~unsup;
            default: trap = 1'b0;
        endcase
`else
        // Without trapping, H ignores addr[0] and W ignores addr[1:0]; the lane
        // selection below never looks at those bits, so nothing else is needed.
        trap = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (unsup || trap) begin
                        state_nxt = S_RESP;
                    end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_read  = ~rst;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                state_nxt = store_q ? S_WR : S_RESP;
            end
            S_WR: begin
                // Gated by reset so a reset landing here never commits a write.
                mem_write = ~rst;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load formatting and store merge from the word returned in CAP
    always_comb begin
        lane_b = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_fmt = {24'h0, lane_b};
            3'b101:  load_fmt = {16'h0, lane_h};
            default: load_fmt = mem_read_data;
        endcase
        merged = mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Captured request and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            funct3_q  <= 3'b000;
            store_q   <= 1'b0;
            wdata_q   <= 16'h0;
            rdata_q   <= 32'h0;
            wr_data_q <= 32'h0;
            misal_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                store_q  <= req_store;
                wdata_q  <= req_wdata[15:0];
                rdata_q  <= 32'h0;
                misal_q  <= trap;
                // SW writes req_wdata directly; SB/SH overwrite this in CAP.
                if (req_store) begin
                    wr_data_q <= req_wdata;
                end
            end
            if (state == S_CAP) begin
                if (store_q) begin
                    wr_data_q <= merged;
                end else begin
                    rdata_q <= load_fmt;
                end
            end
        end
    end

    assign resp_rdata      = rdata_q;
    assign resp_misaligned = misal_q;
    assign mem_address     = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_write_data  = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests checked against a
// byte-array memory model; a simple word memory answers the DUT's memory port.

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    // Data memory: 64 words, registered read, with a preload port.
    logic [31:0] mem_words [64];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_dat;

    always @(posedge clk) begin
        if (init_we) mem_words[init_idx] <= init_dat;
        else if (mem_write) mem_words[mem_address[5:0]] <= mem_write_data;
        if (mem_read) mem_read_data <= mem_words[mem_address[5:0]];
    end

    // Reference: byte-addressed memory image plus the architectural rules.
    logic [7:0] ref_mem [256];

    task automatic ref_apply(input logic st, input logic [2:0] f3, input int a, input logic [31:0] wd,
                             output logic [31:0] e_rd, output logic e_mis, output int e_lat,
                             output int e_nrd, output int e_nwr);
        bit          unsup;
        bit          mis;
        int          sz;
        int          ea;
        logic [31:0] v;
        unsup = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        sz    = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        mis   = !unsup && ((a % sz) != 0);
        ea    = a - (a % sz);
        e_rd  = 32'h0; e_mis = 1'b0; e_nrd = 0; e_nwr = 0; e_lat = 0;
        v     = 32'h0;
        if (unsup) begin
            e_lat = 1;
        end else if (mis && TRAP) begin
            e_lat = 1;
            e_mis = 1'b1;
        end else if (st) begin
            for (int k = 0; k < sz; k++) ref_mem[ea + k] = wd[8*k +: 8];
            e_nwr = 1;
            if (sz == 4) e_lat = 2;
            else begin e_lat = 4; e_nrd = 1; end
        end else begin
            for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[ea + k];
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            e_rd  = v;
            e_nrd = 1;
            e_lat = 3;
        end
    endtask

    // Issue one request and observe it until resp_valid (bounded).
    task automatic do_req(input logic st, input logic [2:0] f3, input int a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output int lat,
                          output int nrd, output int nwr, output logic [31:0] maddr, output int wcyc);
        int n;
        rd = 32'h0; mis = 1'b0; lat = -1; nrd = 0; nwr = 0; maddr = 32'hFFFF_FFFF; wcyc = -1;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read) begin nrd++; maddr = mem_address; end
            if (mem_write) begin nwr++; maddr = mem_address; wcyc = c; end
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                mis = resp_misaligned;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
        n_vec++; if (resp_misaligned !== 1'b0) begin n_err++; $display("FAIL reset resp_misaligned: got %b want 0", resp_misaligned); end
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset mem_read: got %b want 0", mem_read); end
        n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset mem_write: got %b want 0", mem_write); end
        n_vec++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL reset mem_address: got %h want 0", mem_address); end
        n_vec++; if (mem_write_data !== 32'h0) begin n_err++; $display("FAIL reset mem_write_data: got %h want 0", mem_write_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd, erd, ma;
        logic        mis, emis;
        int          lat, elat, nrd, enrd, nwr, enwr, wc;
        ref_apply(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, erd, emis, elat, enrd, enwr);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, mis, lat, nrd, nwr, ma, wc);
        n_vec++; if (wc !== 1) begin n_err++; $display("FAIL sw write cycle: got %0d want 1", wc); end
        n_vec++; if (ma !== 32'h4) begin n_err++; $display("FAIL sw mem_address: got %h want 4", ma); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sw latency: got %0d want 2", lat); end
        n_vec++; if (mem_words[4] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw memory: got %h want deadbeef", mem_words[4]); end
        ref_apply(1'b0, 3'd2, 32'h10, 32'h0, erd, emis, elat, enrd, enwr);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, mis, lat, nrd, nwr, ma, wc);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw data: got %h want deadbeef", rd); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL lw latency: got %0d want 3", lat); end
    endtask

    task automatic test_subword(input logic [2:0] st_f3, input int st_a, input logic [31:0] st_d,
                                input logic [31:0] exp_word, input logic [2:0] lf [3],
                                input int la [3], input logic [31:0] lexp [3]);
        logic [31:0] rd, erd, ma;
        logic        mis, emis;
        int          lat, elat, nrd, enrd, nwr, enwr, wc;
        ref_apply(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, erd, emis, elat, enrd, enwr);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, mis, lat, nrd, nwr, ma, wc);
        ref_apply(1'b1, st_f3, st_a, st_d, erd, emis, elat, enrd, enwr);
        do_req(1'b1, st_f3, st_a, st_d, rd, mis, lat, nrd, nwr, ma, wc);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL sub store latency f3=%0d: got %0d want 4", st_f3, lat); end
        n_vec++; if (mem_words[4] !== exp_word) begin n_err++; $display("FAIL sub store word f3=%0d: got %h want %h", st_f3, mem_words[4], exp_word); end
        for (int i = 0; i < 3; i++) begin
            ref_apply(1'b0, lf[i], la[i], 32'h0, erd, emis, elat, enrd, enwr);
            do_req(1'b0, lf[i], la[i], 32'h0, rd, mis, lat, nrd, nwr, ma, wc);
            n_vec++; if (rd !== lexp[i]) begin n_err++; $display("FAIL sub load f3=%0d addr=%h: got %h want %h", lf[i], la[i], rd, lexp[i]); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, erd, ma;
        logic        mis, emis;
        int          lat, elat, nrd, enrd, nwr, enwr, wc;
        ref_apply(1'b0, 3'd2, 32'h11, 32'h0, erd, emis, elat, enrd, enwr);
        do_req(1'b0, 3'd2, 32'h11, 32'h0, rd, mis, lat, nrd, nwr, ma, wc);
        if (TRAP) begin
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL misal latency: got %0d want 1", lat); end
            n_vec++; if (mis !== 1'b1) begin n_err++; $display("FAIL misal flag: got %b want 1", mis); end
            n_vec++; if (nrd + nwr !== 0) begin n_err++; $display("FAIL misal strobes: got %0d want 0", nrd + nwr); end
        end else begin
            n_vec++; if (ma !== 32'h4) begin n_err++; $display("FAIL misal word addr: got %h want 4", ma); end
            n_vec++; if (rd !== mem_words[4]) begin n_err++; $display("FAIL misal data: got %h want %h", rd, mem_words[4]); end
            n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL misal flag: got %b want 0", mis); end
        end
        n_vec++; if (rd !== erd) begin n_err++; $display("FAIL misal model data: got %h want %h", rd, erd); end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd, erd, ma;
        logic        mis, emis;
        int          lat, elat, nrd, enrd, nwr, enwr, wc, nw, nv;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h55;
        @(negedge clk);
        @(posedge clk); #1;          // accept edge
        req_valid = 1'b0;
        @(posedge clk); #1;          // now in CAP
        rst = 1'b1;
        nw = 0; nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_write) nw++;
            if (resp_valid) nv++;
            @(posedge clk); #1;
            if (k == 1) rst = 1'b0;
        end
        n_vec++; if (nw !== 0) begin n_err++; $display("FAIL rst mid-store mem_write: got %0d want 0", nw); end
        n_vec++; if (nv !== 0) begin n_err++; $display("FAIL rst mid-store resp_valid: got %0d want 0", nv); end
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst mid-store req_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
        ref_apply(1'b0, 3'd2, 32'h10, 32'h0, erd, emis, elat, enrd, enwr);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, mis, lat, nrd, nwr, ma, wc);
        n_vec++; if (rd !== erd) begin n_err++; $display("FAIL rst mid-store reload: got %h want %h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0, e1, erd;
        logic        emis;
        int          elat, enrd, enwr, na, nr;
        int          acc_c [4];
        int          rsp_c [4];
        logic [31:0] rsp_d [4];
        ref_apply(1'b0, 3'd2, 32'h20, 32'h0, e0, emis, elat, enrd, enwr);
        ref_apply(1'b0, 3'd2, 32'h24, 32'h0, e1, emis, elat, enrd, enwr);
        erd = 32'h0;
        na = 0; nr = 0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_valid && req_ready && na < 4) begin acc_c[na] = k; na++; end
            if (resp_valid && nr < 4) begin rsp_c[nr] = k; rsp_d[nr] = resp_rdata; nr++; end
            @(posedge clk); #1;
            if (na == 1) req_addr = 32'h24;
            if (na == 2) req_valid = 1'b0;
        end
        n_vec++; if (na !== 2) begin n_err++; $display("FAIL b2b accepts: got %0d want 2", na); end
        n_vec++; if (nr !== 2) begin n_err++; $display("FAIL b2b responses: got %0d want 2", nr); end
        if (na == 2 && nr == 2) begin
            n_vec++; if (acc_c[1] !== rsp_c[0] + 1) begin n_err++; $display("FAIL b2b second accept cycle: got %0d want %0d", acc_c[1], rsp_c[0] + 1); end
            n_vec++; if (rsp_c[0] !== 3) begin n_err++; $display("FAIL b2b first resp cycle: got %0d want 3", rsp_c[0]); end
            n_vec++; if (rsp_d[0] !== e0) begin n_err++; $display("FAIL b2b data0: got %h want %h", rsp_d[0], e0); end
            n_vec++; if (rsp_d[1] !== e1) begin n_err++; $display("FAIL b2b data1: got %h want %h", rsp_d[1], e1); end
        end
    endtask

    task automatic test_random(input int count);
        logic [31:0] rd, erd, ma, wd;
        logic        mis, emis, st;
        logic [2:0]  f3;
        int          lat, elat, nrd, enrd, nwr, enwr, wc, a;
        logic [2:0]  st_tab [6];
        st_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < count; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? st_tab[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            wd = $urandom;
            ref_apply(st, f3, a, wd, erd, emis, elat, enrd, enwr);
            do_req(st, f3, a, wd, rd, mis, lat, nrd, nwr, ma, wc);
            n_vec++; if (rd !== erd) begin n_err++; $display("FAIL rand data st=%b f3=%0d a=%h: got %h want %h", st, f3, a, rd, erd); end
            n_vec++; if (mis !== emis) begin n_err++; $display("FAIL rand misal st=%b f3=%0d a=%h: got %b want %b", st, f3, a, mis, emis); end
            n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rand latency st=%b f3=%0d a=%h: got %0d want %0d", st, f3, a, lat, elat); end
            n_vec++; if (nrd !== enrd || nwr !== enwr) begin n_err++; $display("FAIL rand strobes st=%b f3=%0d a=%h: got rd=%0d wr=%0d want rd=%0d wr=%0d", st, f3, a, nrd, nwr, enrd, enwr); end
        end
    endtask

    task automatic test_memory_image();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            n_vec++; if (mem_words[i] !== w) begin n_err++; $display("FAIL memory word %0d: got %h want %h", i, mem_words[i], w); end
        end
    endtask

    logic [2:0]  b_f [3];
    int          b_a [3];
    logic [31:0] b_e [3];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        init_we = 1'b1; init_idx = 6'd0; init_dat = 32'h0;
        #1;
        for (int i = 0; i < 64; i++) begin
            init_idx = i[5:0];
            init_dat = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_dat[8*k +: 8];
            @(posedge clk); #1;
        end
        init_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_word();
        b_f = '{3'd0, 3'd0, 3'd4};
        b_a = '{32'h13, 32'h12, 32'h12};
        b_e = '{32'h0000_007F, 32'hFFFF_FFAD, 32'h0000_00AD};
        test_subword(3'd0, 32'h13, 32'h0000_007F, 32'h7FAD_BEEF, b_f, b_a, b_e);
        b_f = '{3'd1, 3'd5, 3'd1};
        b_a = '{32'h12, 32'h12, 32'h10};
        b_e = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_BEEF};
        test_subword(3'd1, 32'h12, 32'h0000_8001, 32'h8001_BEEF, b_f, b_a, b_e);
        test_misaligned();
        test_reset_mid_store();
        test_back_to_back();
        test_random(300);
        test_memory_image();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
